// File: rtl/multiplicador_seq_8bits_pkg.sv
// rtl/multiplicador_seq_8bits_pkg.sv - shared ULA encodings for the sequential multiplier
// Purpose: FSM state encoding and the iteration count of the shift-and-add loop.
// Optional feature macro: MULT_OVERFLOW_EN (used by the interface and top, not here).
package multiplicador_seq_8bits_pkg;

    typedef enum logic [1:0] {
        ST_OCIOSO  = 2'd0,
        ST_CALCULA = 2'd1,
        ST_FIM     = 2'd2
    } state_t;

    localparam int MULT_ITER = 8;

    // Counter value on which the final iteration happens.
    localparam logic [2:0] CNT_LAST = 3'(MULT_ITER - 1);

endpackage

// File: rtl/multiplicador_seq_8bits_if.sv
// rtl/multiplicador_seq_8bits_if.sv - start/busy/done handshake between ULA top and multiplier
// Signals:
//   start        request from the ULA, sampled only while the multiplier is idle
//   A, B         8-bit multiplicand / multiplier, captured on acceptance
//   P            16-bit registered product
//   busy         high while iterating
//   done         product-valid strobe
//   ovf          |P[15:8], present only when MULT_OVERFLOW_EN is defined
// Modports: master = ULA side, slave = multiplier side.
interface multiplicador_seq_8bits_if;

    logic        start;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] P;
    logic        busy;
    logic        done;
`ifdef MULT_OVERFLOW_EN
    logic        ovf;
`endif

    modport master (
        output start, A, B,
        input  P, busy, done
`ifdef MULT_OVERFLOW_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, A, B,
        output P, busy, done
`ifdef MULT_OVERFLOW_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/somador_8bits.sv
// rtl/somador_8bits.sv - combinational 8-bit adder with carry-out
// Ports:
//   a, b   8-bit operands
//   s      8-bit sum
//   cout   carry-out
module somador_8bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] s,
    output logic       cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/multiplicador_seq_8bits.sv
// rtl/multiplicador_seq_8bits.sv - sequential 8x8 unsigned shift-and-add multiplier
// Purpose: 8 iterations per operation through a single somador_8bits instance,
//          producing a 16-bit product with a start/busy/done handshake.
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   bus    multiplicador_seq_8bits_if.slave (start, A, B, P, busy, done[, ovf])
// Parameters:
//   DONE_HOLD  0: done is a one-cycle pulse; 1: done holds until next accepted start or reset
// Optional feature macro: MULT_OVERFLOW_EN adds registered ovf = |P[15:8].
module multiplicador_seq_8bits
    import multiplicador_seq_8bits_pkg::*;
#(
    parameter bit DONE_HOLD = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    multiplicador_seq_8bits_if.slave      bus
);

    state_t      state_q, state_d;
    logic [7:0]  m_q, m_d;
    logic [7:0]  h_q, h_d;
    logic [7:0]  l_q, l_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] p_q, p_d;
    logic        done_q, done_d;
`ifdef MULT_OVERFLOW_EN
    logic        ovf_q, ovf_d;
`endif

    logic [7:0]  add_b;
    logic [7:0]  sum;
    logic        carry;

    // Multiplier LSB selects whether the multiplicand is accumulated this step.
    assign add_b = l_q[0] ? m_q : 8'h00;

    somador_8bits u_somador (
        .a    (h_q),
        .b    (add_b),
        .s    (sum),
        .cout (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_OCIOSO;
            m_q     <= '0;
            h_q     <= '0;
            l_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
`ifdef MULT_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            h_q     <= h_d;
            l_q     <= l_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            done_q  <= done_d;
`ifdef MULT_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        h_d     = h_q;
        l_d     = l_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        done_d  = done_q;
`ifdef MULT_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_OCIOSO: begin
                if (bus.start) begin
                    m_d     = bus.A;
                    l_d     = bus.B;
                    h_d     = 8'h00;
                    cnt_d   = 3'd0;
                    done_d  = 1'b0;
                    state_d = ST_CALCULA;
                end
            end
            ST_CALCULA: begin
                // The 17-bit {carry, sum, L} shifted right by one: the carry is
                // always absorbed into H, so the product cannot overflow 16 bits.
                h_d   = {carry, sum[7:1]};
                l_d   = {sum[0], l_q[7:1]};
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) begin
                    p_d     = {carry, sum[7:1], sum[0], l_q[7:1]};
                    done_d  = 1'b1;
                    state_d = ST_FIM;
`ifdef MULT_OVERFLOW_EN
                    ovf_d   = |{carry, sum[7:1]};
`endif
                end
            end
            ST_FIM: begin
                done_d  = DONE_HOLD;
                state_d = ST_OCIOSO;
            end
            default: begin
                state_d = ST_OCIOSO;
            end
        endcase
    end

    assign bus.P    = p_q;
    assign bus.busy = (state_q == ST_CALCULA);
    assign bus.done = done_q;
`ifdef MULT_OVERFLOW_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_multiplicador_seq_8bits.sv
// tb/tb_multiplicador_seq_8bits.sv - directed-vector bench for multiplicador_seq_8bits
// Two instances share stimulus: dut (DONE_HOLD=0) and dut_h (DONE_HOLD=1).
// Optional feature macro: MULT_OVERFLOW_EN enables ovf checks.
module tb_multiplicador_seq_8bits;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nmis = 0;

    always #5 clk = ~clk;

    multiplicador_seq_8bits_if mif ();
    multiplicador_seq_8bits_if hif ();

    assign hif.start = mif.start;
    assign hif.A     = mif.A;
    assign hif.B     = mif.B;

    multiplicador_seq_8bits #(.DONE_HOLD(1'b0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif)
    );

    multiplicador_seq_8bits #(.DONE_HOLD(1'b1)) dut_h (
        .clk (clk),
        .rst (rst),
        .bus (hif)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one operation; inject_at >= 0 pulses a stray start with 0x12/0x34
    // during that busy cycle (0-based).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input int inject_at);
        @(negedge clk);
        mif.start = 1'b1;
        mif.A     = a;
        mif.B     = b;
        @(negedge clk);
        mif.start = 1'b0;
        mif.A     = ~a;
        mif.B     = ~b;
        for (int i = 0; i < 8; i++) begin
            check_eq("busy_calc", {31'd0, mif.busy}, 32'd1);
            check_eq("done_calc", {31'd0, mif.done}, 32'd0);
            check_eq("done_h_calc", {31'd0, hif.done}, 32'd0);
            if (i == inject_at) begin
                mif.start = 1'b1;
                mif.A     = 8'h12;
                mif.B     = 8'h34;
            end else begin
                mif.start = 1'b0;
            end
            @(negedge clk);
        end
        mif.start = 1'b0;
        check_eq("busy_fim", {31'd0, mif.busy}, 32'd0);
        check_eq("done_fim", {31'd0, mif.done}, 32'd1);
        check_eq("done_h_fim", {31'd0, hif.done}, 32'd1);
        check_eq("p", {16'd0, mif.P}, {16'd0, exp_p});
        check_eq("p_h", {16'd0, hif.P}, {16'd0, exp_p});
`ifdef MULT_OVERFLOW_EN
        check_eq("ovf", {31'd0, mif.ovf}, {31'd0, |exp_p[15:8]});
`endif
        @(negedge clk);
        check_eq("done_after", {31'd0, mif.done}, 32'd0);
        check_eq("done_h_after", {31'd0, hif.done}, 32'd1);
        check_eq("busy_after", {31'd0, mif.busy}, 32'd0);
        check_eq("p_hold", {16'd0, mif.P}, {16'd0, exp_p});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        int first_rise;
        int last_rise;
        int busy_cnt;
        int done_cnt;
        int done_h_cnt;
        logic busy_prev;

        rst       = 1'b1;
        mif.start = 1'b0;
        mif.A     = 8'h00;
        mif.B     = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_p", {16'd0, mif.P}, 32'd0);
        check_eq("rst_busy", {31'd0, mif.busy}, 32'd0);
        check_eq("rst_done", {31'd0, mif.done}, 32'd0);
        check_eq("rst_done_h", {31'd0, hif.done}, 32'd0);
`ifdef MULT_OVERFLOW_EN
        check_eq("rst_ovf", {31'd0, mif.ovf}, 32'd0);
`endif

        run_op(8'h0D, 8'h0B, 16'h008F, -1);
        run_op(8'hFF, 8'hFF, 16'hFE01, -1);
        run_op(8'h0F, 8'h03, 16'h002D, -1);
        run_op(8'h00, 8'hA5, 16'h0000, -1);
        run_op(8'hA5, 8'h00, 16'h0000, -1);

        run_op(8'h0D, 8'h0B, 16'h008F, 2);
        for (int i = 0; i < 12; i++) begin
            check_eq("no_extra_busy", {31'd0, mif.busy}, 32'd0);
            check_eq("no_extra_done", {31'd0, mif.done}, 32'd0);
            check_eq("p_kept", {16'd0, mif.P}, 32'h0000008F);
            @(negedge clk);
        end

        // Reset in the middle of an operation.
        mif.start = 1'b1;
        mif.A     = 8'h0D;
        mif.B     = 8'h0B;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst_busy", {31'd0, mif.busy}, 32'd0);
        check_eq("midrst_done", {31'd0, mif.done}, 32'd0);
        check_eq("midrst_done_h", {31'd0, hif.done}, 32'd0);
        check_eq("midrst_p", {16'd0, mif.P}, 32'd0);
        repeat (10) @(negedge clk);
        check_eq("midrst_no_done", {31'd0, mif.done}, 32'd0);
        check_eq("midrst_no_p", {16'd0, mif.P}, 32'd0);
        run_op(8'h02, 8'h03, 16'h0006, -1);

        // Back-to-back with start held high for 32 sampled cycles.
        rises      = 0;
        first_rise = 0;
        last_rise  = 0;
        busy_cnt   = 0;
        done_cnt   = 0;
        done_h_cnt = 0;
        busy_prev  = 1'b0;
        @(negedge clk);
        mif.start = 1'b1;
        mif.A     = 8'h03;
        mif.B     = 8'h05;
        for (int n = 1; n <= 32; n++) begin
            @(negedge clk);
            if (mif.busy && !busy_prev) begin
                rises++;
                if (rises == 1) first_rise = n;
                last_rise = n;
            end
            busy_prev = mif.busy;
            if (mif.busy) busy_cnt++;
            if (mif.done) done_cnt++;
            if (hif.done) done_h_cnt++;
            if (n == 9 || n == 19 || n == 29)
                check_eq("b2b_p", {16'd0, mif.P}, 32'h0000000F);
        end
        mif.start = 1'b0;
        check_eq("b2b_rises", rises, 4);
        check_eq("b2b_first", first_rise, 1);
        check_eq("b2b_last", last_rise, 31);
        check_eq("b2b_busy_cycles", busy_cnt, 26);
        check_eq("b2b_done_pulses", done_cnt, 3);
        check_eq("b2b_done_h_cycles", done_h_cnt, 6);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
